// File: rtl/cajero_pkg.sv
// Shared types and default sizes for the ATM transaction controller.
package cajero_pkg;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        PIN       = 2'd1,
        MONTO     = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    localparam int PIN_DIGITOS      = 4;
    localparam int MAX_INTENTOS_DEF = 3;
    localparam int ADV_INTENTOS_DEF = 2;
    localparam int BAL_W_DEF        = 64;
    localparam int MONTO_W_DEF      = 32;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: one-cycle combinational pulse when the input goes 0 -> 1.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic flanco
);

    logic previo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) previo <= 1'b0;
        else        previo <= entrada;
    end

    assign flanco = entrada & ~previo;

endmodule

// File: rtl/cajero_transaccion.sv
// ATM transaction controller: PIN entry, deposit/withdrawal on the card balance, lockout.
// state     | meaning
// ESPERA    | idle, waiting for a card
// PIN       | collecting 4 BCD keypad digits
// MONTO     | PIN accepted, waiting for the amount strobe
// BLOQUEADO | card locked, only reset leaves
module cajero_transaccion
    import cajero_pkg::*;
#(
    parameter int MAX_INTENTOS = MAX_INTENTOS_DEF,
    parameter int ADV_INTENTOS = ADV_INTENTOS_DEF,
    parameter int BAL_W        = BAL_W_DEF,
    parameter int MONTO_W      = MONTO_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 TARJETA_RECIBIDA,
    input  logic                 TIPO_TRANS,
    input  logic [15:0]          PIN,
    input  logic [3:0]           DIGITO,
    input  logic                 DIGITO_STB,
    input  logic [MONTO_W-1:0]   MONTO,
    input  logic                 MONTO_STB,
    input  logic [BAL_W-1:0]     BALANCE_INICIAL,
    output logic [BAL_W-1:0]     BALANCE,
    output logic                 BALANCE_ACTUALIZADO,
    output logic                 ENTREGAR_DINERO,
    output logic                 PIN_INCORRECTO,
    output logic                 ADVERTENCIA,
    output logic                 BLOQUEO,
    output logic                 FONDOS_INSUFICIENTES
);

    localparam int INT_W = $clog2(MAX_INTENTOS + 1);
    localparam int CNT_W = $clog2(PIN_DIGITOS + 1);

    estado_t            estado, estado_d;
    logic [BAL_W-1:0]   balance_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [INT_W-1:0]   intentos, intentos_d, intentos_inc;
    logic [15:0]        sreg, sreg_d, pin_sig;
    logic               adv_d, bloq_d, act_d, entregar_d, pin_inc_d, fondos_d;
    logic               flanco_dig, flanco_mon;
    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     suma;

    detector_flanco u_flanco_dig (
        .clk     (Clk),
        .rst_n   (Reset),
        .entrada (DIGITO_STB),
        .flanco  (flanco_dig)
    );

    detector_flanco u_flanco_mon (
        .clk     (Clk),
        .rst_n   (Reset),
        .entrada (MONTO_STB),
        .flanco  (flanco_mon)
    );

    assign pin_sig      = {sreg[11:0], DIGITO};
    assign intentos_inc = intentos + 1'b1;
    assign monto_ext    = BAL_W'(MONTO);
    assign suma         = {1'b0, BALANCE} + {1'b0, monto_ext};

    always_comb begin
        estado_d   = estado;
        balance_d  = BALANCE;
        cnt_d      = cnt;
        intentos_d = intentos;
        sreg_d     = sreg;
        adv_d      = ADVERTENCIA;
        bloq_d     = BLOQUEO;
        act_d      = 1'b0;
        entregar_d = 1'b0;
        pin_inc_d  = 1'b0;
        fondos_d   = 1'b0;
        case (estado)
            cajero_pkg::ESPERA: begin
                if (TARJETA_RECIBIDA) begin
                    balance_d  = BALANCE_INICIAL;
                    intentos_d = '0;
                    cnt_d      = '0;
                    sreg_d     = '0;
                    adv_d      = 1'b0;
                    estado_d   = cajero_pkg::PIN;
                end
            end
            cajero_pkg::PIN: begin
                if (!TARJETA_RECIBIDA) begin
                    estado_d = cajero_pkg::ESPERA;
                end else if (flanco_dig) begin
                    sreg_d = pin_sig;
                    cnt_d  = cnt + 1'b1;
                    // last digit: compare the word including the digit arriving now
                    if (cnt == CNT_W'(PIN_DIGITOS - 1)) begin
                        cnt_d  = '0;
                        sreg_d = '0;
                        if (pin_sig == PIN) begin
                            intentos_d = '0;
                            adv_d      = 1'b0;
                            estado_d   = cajero_pkg::MONTO;
                        end else begin
                            pin_inc_d  = 1'b1;
                            intentos_d = intentos_inc;
                            if (intentos_inc == INT_W'(ADV_INTENTOS)) adv_d = 1'b1;
                            if (intentos_inc == INT_W'(MAX_INTENTOS)) begin
                                bloq_d   = 1'b1;
                                adv_d    = 1'b0;
                                estado_d = cajero_pkg::BLOQUEADO;
                            end
                        end
                    end
                end
            end
            cajero_pkg::MONTO: begin
                if (!TARJETA_RECIBIDA) begin
                    estado_d = cajero_pkg::ESPERA;
                end else if (flanco_mon) begin
                    estado_d = cajero_pkg::ESPERA;
                    if (!TIPO_TRANS) begin
                        balance_d = suma[BAL_W] ? '1 : suma[BAL_W-1:0];
                        act_d     = 1'b1;
                    end else if (monto_ext <= BALANCE) begin
                        balance_d  = BALANCE - monto_ext;
                        act_d      = 1'b1;
                        entregar_d = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
                end
            end
            cajero_pkg::BLOQUEADO: begin
                bloq_d = 1'b1;
            end
            default: estado_d = cajero_pkg::ESPERA;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            estado               <= cajero_pkg::ESPERA;
            BALANCE              <= '0;
            cnt                  <= '0;
            intentos             <= '0;
            sreg                 <= '0;
            ADVERTENCIA          <= 1'b0;
            BLOQUEO              <= 1'b0;
            BALANCE_ACTUALIZADO  <= 1'b0;
            ENTREGAR_DINERO      <= 1'b0;
            PIN_INCORRECTO       <= 1'b0;
            FONDOS_INSUFICIENTES <= 1'b0;
        end else begin
            estado               <= estado_d;
            BALANCE              <= balance_d;
            cnt                  <= cnt_d;
            intentos             <= intentos_d;
            sreg                 <= sreg_d;
            ADVERTENCIA          <= adv_d;
            BLOQUEO              <= bloq_d;
            BALANCE_ACTUALIZADO  <= act_d;
            ENTREGAR_DINERO      <= entregar_d;
            PIN_INCORRECTO       <= pin_inc_d;
            FONDOS_INSUFICIENTES <= fondos_d;
        end
    end

endmodule

// File: tb/tb_cajero_transaccion.sv
// Bench for cajero_transaccion: session-level reference model plus directed scenarios.
module tb_cajero_transaccion;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        TARJETA_RECIBIDA = 1'b0;
    logic        TIPO_TRANS = 1'b0;
    logic [15:0] PIN = 16'h0259;
    logic [3:0]  DIGITO = 4'd0;
    logic        DIGITO_STB = 1'b0;
    logic [31:0] MONTO = '0;
    logic        MONTO_STB = 1'b0;
    logic [63:0] BALANCE_INICIAL = '0;
    logic [63:0] BALANCE;
    logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
    logic        ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES;

    int cmp_cnt = 0;
    int err_cnt = 0;

    cajero_transaccion dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
        .TIPO_TRANS           (TIPO_TRANS),
        .PIN                  (PIN),
        .DIGITO               (DIGITO),
        .DIGITO_STB           (DIGITO_STB),
        .MONTO                (MONTO),
        .MONTO_STB            (MONTO_STB),
        .BALANCE_INICIAL      (BALANCE_INICIAL),
        .BALANCE              (BALANCE),
        .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
        .ENTREGAR_DINERO      (ENTREGAR_DINERO),
        .PIN_INCORRECTO       (PIN_INCORRECTO),
        .ADVERTENCIA          (ADVERTENCIA),
        .BLOQUEO              (BLOQUEO),
        .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a card session with a digit queue, failure count and lock flag.
    bit          m_session = 0, m_authed = 0, m_locked = 0, m_pd = 0, m_pm = 0;
    int          m_fails = 0;
    int          m_digits[$];
    logic [63:0] m_bal = '0;
    bit          e_act = 0, e_ent = 0, e_pin = 0, e_adv = 0, e_fon = 0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_session = 0; m_authed = 0; m_locked = 0; m_pd = 0; m_pm = 0;
            m_fails = 0; m_digits.delete(); m_bal = '0;
            e_act = 0; e_ent = 0; e_pin = 0; e_adv = 0; e_fon = 0;
        end else begin
            bit dig_edge, mon_edge;
            int entered;
            logic [63:0] amt;
            dig_edge = DIGITO_STB && !m_pd;
            mon_edge = MONTO_STB && !m_pm;
            m_pd = DIGITO_STB;
            m_pm = MONTO_STB;
            e_act = 0; e_ent = 0; e_pin = 0; e_fon = 0;
            if (m_locked) begin
                // card retained until reset
            end else if (!m_session) begin
                if (TARJETA_RECIBIDA) begin
                    m_session = 1; m_authed = 0; m_bal = BALANCE_INICIAL;
                    m_fails = 0; m_digits.delete(); e_adv = 0;
                end
            end else if (!TARJETA_RECIBIDA) begin
                m_session = 0; m_authed = 0; m_digits.delete();
            end else if (!m_authed) begin
                if (dig_edge) begin
                    m_digits.push_back(int'(DIGITO));
                    if (m_digits.size() == 4) begin
                        entered = 0;
                        foreach (m_digits[i]) entered = entered * 16 + m_digits[i];
                        m_digits.delete();
                        if (entered == int'(PIN)) begin
                            m_authed = 1; m_fails = 0; e_adv = 0;
                        end else begin
                            e_pin = 1;
                            m_fails++;
                            if (m_fails == 2) e_adv = 1;
                            if (m_fails == 3) begin m_locked = 1; e_adv = 0; end
                        end
                    end
                end
            end else if (mon_edge) begin
                amt = {32'd0, MONTO};
                if (!TIPO_TRANS) begin
                    m_bal = (m_bal > ~amt) ? 64'hFFFF_FFFF_FFFF_FFFF : m_bal + amt;
                    e_act = 1;
                end else if (amt <= m_bal) begin
                    m_bal = m_bal - amt; e_act = 1; e_ent = 1;
                end else begin
                    e_fon = 1;
                end
                m_session = 0; m_authed = 0;
            end
        end
    end

    always @(negedge Clk) begin
        chk("BALANCE", BALANCE, m_bal);
        chk("BALANCE_ACTUALIZADO", BALANCE_ACTUALIZADO, e_act);
        chk("ENTREGAR_DINERO", ENTREGAR_DINERO, e_ent);
        chk("PIN_INCORRECTO", PIN_INCORRECTO, e_pin);
        chk("ADVERTENCIA", ADVERTENCIA, e_adv);
        chk("BLOQUEO", BLOQUEO, m_locked);
        chk("FONDOS_INSUFICIENTES", FONDOS_INSUFICIENTES, e_fon);
    end

    // Stimulus helpers; inputs change 2 ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic digito(input logic [3:0] d, input int hold = 1);
        DIGITO = d;
        DIGITO_STB = 1'b1;
        repeat (hold) tick();
    endtask

    task automatic soltar_digito();
        DIGITO_STB = 1'b0;
        tick();
    endtask

    task automatic tecla(input logic [3:0] d);
        digito(d);
        soltar_digito();
    endtask

    task automatic pin4(input logic [15:0] p);
        tecla(p[15:12]);
        tecla(p[11:8]);
        tecla(p[7:4]);
        digito(p[3:0]);
    endtask

    task automatic monto(input logic tipo, input logic [31:0] m);
        TIPO_TRANS = tipo;
        MONTO = m;
        MONTO_STB = 1'b1;
        tick();
    endtask

    task automatic tarjeta(input logic [63:0] bal);
        BALANCE_INICIAL = bal;
        TARJETA_RECIBIDA = 1'b1;
        tick();
    endtask

    task automatic fin_sesion();
        MONTO_STB = 1'b0;
        DIGITO_STB = 1'b0;
        TARJETA_RECIBIDA = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b0;
        repeat (2) tick();
        chk("reset BALANCE", BALANCE, 64'd0);
        chk("reset BLOQUEO", BLOQUEO, 1'b0);
        Reset = 1'b1;
        tick();

        // deposit 500 on 1000
        tarjeta(64'd1000);
        pin4(16'h0259);
        chk("ok pin no PIN_INCORRECTO", PIN_INCORRECTO, 1'b0);
        soltar_digito();
        monto(1'b0, 32'd500);
        chk("dep BALANCE", BALANCE, 64'd1500);
        chk("dep ACTUALIZADO", BALANCE_ACTUALIZADO, 1'b1);
        chk("dep no ENTREGAR", ENTREGAR_DINERO, 1'b0);
        fin_sesion();
        chk("dep BALANCE held", BALANCE, 64'd1500);

        // withdrawal 500 on 1000, with an ignored amount strobe during PIN entry
        tarjeta(64'd1000);
        tecla(4'd0);
        monto(1'b1, 32'd900);
        MONTO_STB = 1'b0;
        tecla(4'd2);
        tecla(4'd5);
        digito(4'd9);
        soltar_digito();
        tecla(4'd7);
        monto(1'b1, 32'd500);
        chk("wd BALANCE", BALANCE, 64'd500);
        chk("wd ACTUALIZADO", BALANCE_ACTUALIZADO, 1'b1);
        chk("wd ENTREGAR", ENTREGAR_DINERO, 1'b1);
        tick();
        chk("wd ENTREGAR one cycle", ENTREGAR_DINERO, 1'b0);
        fin_sesion();

        // withdrawal equal to balance
        tarjeta(64'd1000);
        pin4(16'h0259);
        soltar_digito();
        monto(1'b1, 32'd1000);
        chk("wd eq BALANCE", BALANCE, 64'd0);
        chk("wd eq ENTREGAR", ENTREGAR_DINERO, 1'b1);
        fin_sesion();

        // insufficient funds
        tarjeta(64'd1000);
        pin4(16'h0259);
        soltar_digito();
        monto(1'b1, 32'd5000);
        chk("nsf FONDOS", FONDOS_INSUFICIENTES, 1'b1);
        chk("nsf BALANCE", BALANCE, 64'd1000);
        chk("nsf no ENTREGAR", ENTREGAR_DINERO, 1'b0);
        fin_sesion();

        // deposit saturates at all-ones
        tarjeta(64'hFFFF_FFFF_FFFF_FFF0);
        pin4(16'h0259);
        soltar_digito();
        monto(1'b0, 32'd100);
        chk("sat BALANCE", BALANCE, 64'hFFFF_FFFF_FFFF_FFFF);
        fin_sesion();

        // one wrong PIN then correct, deposit 5000
        tarjeta(64'd1000);
        pin4(16'h1111);
        chk("wrong PIN_INCORRECTO", PIN_INCORRECTO, 1'b1);
        chk("wrong ADVERTENCIA", ADVERTENCIA, 1'b0);
        soltar_digito();
        pin4(16'h0259);
        soltar_digito();
        monto(1'b0, 32'd5000);
        chk("retry BALANCE", BALANCE, 64'd6000);
        fin_sesion();

        // strobe held 4 cycles counts once; abort after 2 digits
        tarjeta(64'd300);
        digito(4'd0, 4);
        soltar_digito();
        tecla(4'd2);
        fin_sesion();
        chk("abort BALANCE kept", BALANCE, 64'd300);
        tarjeta(64'd300);
        pin4(16'h0259);
        chk("fresh entry no PIN_INCORRECTO", PIN_INCORRECTO, 1'b0);
        soltar_digito();
        monto(1'b0, 32'd7);
        chk("fresh entry BALANCE", BALANCE, 64'd307);
        fin_sesion();

        // lockout
        tarjeta(64'd1000);
        pin4(16'h1111);
        soltar_digito();
        chk("lock adv after 1", ADVERTENCIA, 1'b0);
        pin4(16'h2222);
        chk("lock ADVERTENCIA after 2", ADVERTENCIA, 1'b1);
        soltar_digito();
        pin4(16'h3333);
        chk("lock PIN_INCORRECTO 3rd", PIN_INCORRECTO, 1'b1);
        chk("lock BLOQUEO", BLOQUEO, 1'b1);
        chk("lock ADVERTENCIA cleared", ADVERTENCIA, 1'b0);
        soltar_digito();
        pin4(16'h0259);
        soltar_digito();
        monto(1'b0, 32'd10);
        chk("locked ignores amount", BALANCE_ACTUALIZADO, 1'b0);
        chk("locked BLOQUEO held", BLOQUEO, 1'b1);
        MONTO_STB = 1'b0;
        TARJETA_RECIBIDA = 1'b0;
        tick();
        Reset = 1'b0;
        #5;
        chk("post-lock reset BLOQUEO", BLOQUEO, 1'b0);
        chk("post-lock reset BALANCE", BALANCE, 64'd0);
        Reset = 1'b1;
        tick();

        // after reset a session works again
        tarjeta(64'd50);
        pin4(16'h0259);
        soltar_digito();
        monto(1'b1, 32'd20);
        chk("post-reset BALANCE", BALANCE, 64'd30);
        fin_sesion();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
